// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB slice first.
// Operands are latched on accept; s/cout/ovf update only when the last slice completes.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// ADD   | one CHUNK-bit slice added per edge, busy high
// DONE  | result valid, done high for this single cycle
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N    = WIDTH / CHUNK;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(N - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CNTW-1:0]  cnt;
  logic [CHUNK:0]   slice_sum;
  logic             msb_cin;

  // Operands shift right each cycle so the active slice is always at the bottom;
  // finished slices enter the accumulator from the top.
  always_comb begin
    slice_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    acc_nxt   = (acc >> CHUNK) | (WIDTH'(slice_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_cin   = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ slice_sum[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            acc   <= '0;
            cnt   <= LAST;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          acc   <= acc_nxt;
          carry <= slice_sum[CHUNK];
          if (cnt == '0) begin
            s     <= acc_nxt;
            cout  <= slice_sum[CHUNK];
            ovf   <= msb_cin ^ slice_sum[CHUNK];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: a 16/4 instance and an 8/8 (single slice) instance,
// expected results queued at accept and checked when done pulses.
module tb_seq_chunk_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [15:0] a1 = '0, b1 = '0;
  logic [15:0] s1;
  logic        cout1, ovf1, busy1, done1;
  logic        start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic [7:0]  s2;
  logic        cout2, ovf2, busy2, done2;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
    .s(s2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic icin, input logic isub);
    logic [15:0] bb;
    logic [16:0] r;
    exp_t        e;
    bb     = isub ? ~ib : ib;
    r      = {1'b0, ia} + {1'b0, bb} + {16'd0, (isub ? 1'b1 : icin)};
    e.s    = r[15:0];
    e.cout = r[16];
    e.ovf  = (ia[15] == bb[15]) && (r[15] != ia[15]);
    return e;
  endfunction

  // Accept edge happens inside; returns #1 after it.
  task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic icin, input logic isub);
    a1 = ia; b1 = ib; cin1 = icin; sub1 = isub; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
  endtask

  // first_e = number of edges already elapsed since accept (accept edge excluded).
  task automatic wait16(input string tag, input bit chk_busy, input int first_e);
    bit   seen;
    exp_t x;
    seen = 1'b0;
    if (chk_busy) chk({tag, "_busy_at_accept"}, busy1, 1);
    for (int e = first_e + 1; e <= 20 && !seen; e++) begin
      @(posedge clk); #1;
      if (done1) begin
        seen = 1'b1;
        chk({tag, "_done_latency"}, e, 4);
        chk({tag, "_sb_depth"}, q.size(), 1);
        if (q.size() > 0) begin
          x = q.pop_front();
          chk({tag, "_s"}, s1, x.s);
          chk({tag, "_cout"}, cout1, x.cout);
          chk({tag, "_ovf"}, ovf1, x.ovf);
        end
        chk({tag, "_busy_at_done"}, busy1, 0);
      end else if (chk_busy) begin
        chk({tag, "_busy"}, busy1, 1);
      end
    end
    chk({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, done1, 0);
  endtask

  initial begin
    exp_t x;
    int   extra;
    logic [15:0] ra, rb;
    logic        rc, rs;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", s1, 0);
    chk("rst_cout", cout1, 0);
    chk("rst_ovf", ovf1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    q.push_back('{s: 16'h0000, cout: 1'b0, ovf: 1'b0});
    op16(16'h0000, 16'h0000, 1'b0, 1'b0);
    wait16("zero", 1'b1, 0);

    q.push_back('{s: 16'h0000, cout: 1'b1, ovf: 1'b0});
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait16("ffff_p1", 1'b0, 0);

    q.push_back('{s: 16'h8000, cout: 1'b0, ovf: 1'b1});
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait16("7fff_p1", 1'b0, 0);

    q.push_back('{s: 16'hFFFE, cout: 1'b0, ovf: 1'b0});
    op16(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait16("5_m7", 1'b0, 0);

    q.push_back('{s: 16'h7FFF, cout: 1'b1, ovf: 1'b1});
    op16(16'h8000, 16'h0001, 1'b0, 1'b1);
    wait16("8000_m1", 1'b0, 0);

    // Inputs and start toggle while busy; only the accepted operation may complete.
    q.push_back('{s: 16'h2345, cout: 1'b0, ovf: 1'b0});
    op16(16'h1234, 16'h1111, 1'b0, 1'b0);
    a1 = 16'hFFFF; b1 = 16'hFFFF; sub1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    wait16("busy_start", 1'b0, 1);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done1) extra++;
    end
    chk("busy_start_extra_done", extra, 0);

    // Reset lands on the second ADD cycle: operation aborts silently.
    op16(16'h4444, 16'h2222, 1'b0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_s", s1, 0);
    chk("abort_done", done1, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done1) extra++;
    end
    chk("abort_no_done", extra, 0);

    q.push_back('{s: 16'h1011, cout: 1'b0, ovf: 1'b0});
    op16(16'h0F0F, 16'h0101, 1'b1, 1'b0);
    wait16("after_abort", 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      q.push_back(model(ra, rb, rc, rs));
      op16(ra, rb, rc, rs);
      wait16("rand", 1'b0, 0);
    end
    chk("sb_drained", q.size(), 0);

    // Single-slice instance: done two edges after accept (accept edge counted).
    q8.push_back('{s: 16'h0000, cout: 1'b1, ovf: 1'b0});
    a2 = 8'hFF; b2 = 8'h00; cin2 = 1'b1; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    chk("n1_busy", busy2, 1);
    chk("n1_done_early", done2, 0);
    @(posedge clk); #1;
    chk("n1_done", done2, 1);
    chk("n1_sb_depth", q8.size(), 1);
    if (q8.size() > 0) begin
      x = q8.pop_front();
      chk("n1_s", s2, x.s[7:0]);
      chk("n1_cout", cout2, x.cout);
      chk("n1_ovf", ovf2, x.ovf);
    end
    @(posedge clk); #1;
    chk("n1_done_one_cycle", done2, 0);

    q8.push_back('{s: 16'h0080, cout: 1'b0, ovf: 1'b1});
    a2 = 8'h7F; b2 = 8'h01; cin2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    @(posedge clk); #1;
    chk("n1b_done", done2, 1);
    chk("n1b_sb_depth", q8.size(), 1);
    if (q8.size() > 0) begin
      x = q8.pop_front();
      chk("n1b_s", s2, x.s[7:0]);
      chk("n1b_cout", cout2, x.cout);
      chk("n1b_ovf", ovf2, x.ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
